vga_object_renderer: RTL and testbench
======================================

VGA_OBJECT_RENDERER -- requirements
Module: vga_object_renderer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 24: number of grid objects, range 2..32.
REQ-002 SHALL have parameter CELL_SHIFT, default 5: cell size is 2^CELL_SHIFT pixels square.
REQ-003 SHALL have parameters H_SYNC/H_BP/H_ACT/H_FP, defaults 96/48/640/16: horizontal timing in pixels.
REQ-004 SHALL have parameters V_SYNC/V_BP/V_ACT/V_FP, defaults 2/33/480/10: vertical timing in lines.
REQ-005 SHALL have parameter BG_COLOR, default 9'b000_100_000: background RGB as {r,g,b}.
REQ-006 SHALL have port clk, input, 1: pixel clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port obj_we, input, 1: object-table write strobe.
REQ-009 SHALL have port obj_addr, input, $clog2(NUM_OBJ): object index to write.
REQ-010 SHALL have port obj_wdata, input, 19: {en[18], col[17:13], row[12:9], rgb[8:0]}.
REQ-011 SHALL have ports vga_r, vga_g and vga_b, each output, 3: colour.
REQ-012 SHALL have ports vga_hs and vga_vs, each output, 1: sync, active-low.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse at the frame boundary.
REQ-014 SHALL have port collision, output, 1: object 0 overlapped another object in the previous frame.

Function
REQ-015 SHALL run h_count over 0..H_SYNC+H_BP+H_ACT+H_FP-1 and wrap to 0; at wrap, v_count SHALL advance and wrap over 0..V total-1.
REQ-016 SHALL drive sync low while h_count<H_SYNC (vga_hs) and while v_count<V_SYNC (vga_vs).
REQ-017 SHALL treat the active region as h_count in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_count in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
REQ-018 SHALL compute pixel cell coordinates as (h_count-H_SYNC-H_BP)>>CELL_SHIFT and (v_count-V_SYNC-V_BP)>>CELL_SHIFT.
REQ-019 SHALL keep two object tables, shadow and active; obj_we writes obj_wdata into shadow[obj_addr].
REQ-020 SHALL ignore a write when obj_addr>=NUM_OBJ.
REQ-021 SHALL copy the whole shadow table into the active table on the frame_start cycle.
REQ-022 SHALL, when a write coincides with the copy, copy the pre-write shadow value; the write appears from the following frame.
REQ-023 SHALL mark an object as hit when it is enabled in the active table and its col/row equal the pixel cell.
REQ-024 SHALL output, in active video, the rgb of the lowest-index hit object, or BG_COLOR when no object is hit.
REQ-025 SHALL output colour 0 outside active video.
REQ-026 SHALL pipeline colour, vga_hs and vga_vs identically, with a latency of exactly 2 clk from the counter value to the output.
REQ-027 SHALL pulse frame_start for one cycle when h_count and v_count are both at their maximum.
REQ-028 SHALL ensure objects whose col/row fall outside the visible grid never draw and never collide.

Reset
REQ-029 SHALL, on rst, clear h_count, v_count, frame_start and collision, and clear every enable bit in both tables.
REQ-030 SHALL, on rst, drive vga_hs and vga_vs to 1 and colour to 0 on the next edge.
REQ-031 SHALL, when rst is asserted mid-frame, restart at h=0, v=0 with no frame_start pulse that cycle.

Configuration
REQ-032 SHALL compile collision logic only when VGA_COLLISION_EN is defined.
REQ-033 SHALL, with VGA_COLLISION_EN defined, set an internal hit flag in active video when object 0 is hit together with any other object.
REQ-034 SHALL, with VGA_COLLISION_EN defined, load collision from the hit flag and clear the hit flag on frame_start.
REQ-035 SHALL, without VGA_COLLISION_EN, tie collision to 0 and generate no hit logic.

Verification
REQ-036 SHALL verify: release rst, run 800x525 clocks -> exactly one frame_start; vga_hs low for 96 clk per line; vga_vs low for 2 lines.
REQ-037 SHALL verify: write obj 3 {en=1, col=2, row=1, rgb=9'h1C0} -> pixels x 64..95, y 32..63 show 1C0 from the next frame only, BG_COLOR elsewhere.
REQ-038 SHALL verify: obj 1 and obj 5 both at (4,4) with different rgb -> cell (4,4) shows obj 1 rgb.
REQ-039 SHALL verify: write on the exact frame_start cycle -> the new value is absent this frame and present the next.
REQ-040 SHALL verify, with VGA_COLLISION_EN: obj 0 and obj 7 at (10,3) -> collision=1 after the next frame_start; move obj 7 away -> collision=0 one frame later; without the macro, collision stays 0.
REQ-041 SHALL verify: rst asserted at h=300, v=200 -> next cycle h=0, v=0, sync high, colour 0.

Source files
------------

// File: rtl/vga_object_renderer.sv
// vga_object_renderer
//   VGA timing generator with a grid of coloured rectangular objects.
//   Each object occupies one 2^CELL_SHIFT x 2^CELL_SHIFT pixel cell of the
//   visible area. Objects are written into a shadow table at any time. The
//   shadow table is copied into the active table once per frame, so a frame
//   is always drawn from one consistent set of objects.
//
// Optional feature:
//   VGA_COLLISION_EN - when defined, flags frames in which object 0 shared a
//                      visible cell with any other enabled object.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   obj_we       object-table write strobe
//   obj_addr     object index to write (indices >= NUM_OBJ are ignored)
//   obj_wdata    {en[18], col[17:13], row[12:9], rgb[8:0]}
//   vga_r/g/b    3-bit colour, forced to 0 outside active video
//   vga_hs/vs    active-low sync
//   frame_start  one-cycle pulse while both counters sit at their maximum
//   collision    object 0 overlapped another object in the previous frame
module vga_object_renderer #(
   parameter int          NUM_OBJ    = 24,
   parameter int          CELL_SHIFT = 5,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          H_ACT      = 640,
   parameter int          H_FP       = 16,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter int          V_ACT      = 480,
   parameter int          V_FP       = 10,
   parameter logic [8:0]  BG_COLOR   = 9'b000_100_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       obj_we,
   input  logic [$clog2(NUM_OBJ)-1:0] obj_addr,
   input  logic [18:0]                obj_wdata,
   output logic [2:0]                 vga_r,
   output logic [2:0]                 vga_g,
   output logic [2:0]                 vga_b,
   output logic                       vga_hs,
   output logic                       vga_vs,
   output logic                       frame_start,
   output logic                       collision
);

   localparam int H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HW      = $clog2(H_TOT);
   localparam int VW      = $clog2(V_TOT);
   localparam int AW      = $clog2(NUM_OBJ);
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;

   localparam logic [HW-1:0] H_MAX   = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_MAX   = VW'(V_TOT - 1);
   localparam logic [AW:0]   OBJ_LIM = (AW + 1)'(NUM_OBJ);

   logic [HW-1:0] h_count_q, h_count_d;
   logic [VW-1:0] v_count_q, v_count_d;
   logic          frame_start_q, frame_start_d;

   logic [18:0]   shadow_q [NUM_OBJ];
   logic [18:0]   shadow_d [NUM_OBJ];
   logic [18:0]   active_q [NUM_OBJ];
   logic [18:0]   active_d [NUM_OBJ];

   logic [8:0]    rgb_s1_q, rgb_s1_d;
   logic          hs_s1_q, hs_s1_d;
   logic          vs_s1_q, vs_s1_d;
   logic [8:0]    rgb_q;
   logic          hs_q, vs_q;

   logic [HW-1:0]      x_rel, cell_x;
   logic [VW-1:0]      y_rel, cell_y;
   logic               h_vis, v_vis, video;
   logic [NUM_OBJ-1:0] obj_hit;
   logic [8:0]         pix_rgb;

   // Counters and frame boundary. frame_start_q is decoded from the next
   // counter values so it is high exactly while the counters sit at max.
   always_comb begin
      h_count_d = h_count_q + 1'b1;
      v_count_d = v_count_q;
      if (h_count_q == H_MAX) begin
         h_count_d = '0;
         v_count_d = (v_count_q == V_MAX) ? '0 : v_count_q + 1'b1;
      end
      frame_start_d = (h_count_d == H_MAX) && (v_count_d == V_MAX);
   end

   // Object tables. The copy reads shadow_q, so a write on the frame_start
   // cycle lands in the shadow only and shows up one frame later.
   always_comb begin
      shadow_d = shadow_q;
      if (obj_we && ({1'b0, obj_addr} < OBJ_LIM)) begin
         shadow_d[obj_addr] = obj_wdata;
      end
      active_d = frame_start_q ? shadow_q : active_q;
   end

   // Pixel stage: hit test against the active table for the current counter.
   always_comb begin
      h_vis  = (32'(h_count_q) >= H_START) && (32'(h_count_q) < H_START + H_ACT);
      v_vis  = (32'(v_count_q) >= V_START) && (32'(v_count_q) < V_START + V_ACT);
      video  = h_vis && v_vis;
      x_rel  = h_count_q - HW'(H_START);
      y_rel  = v_count_q - VW'(V_START);
      cell_x = x_rel >> CELL_SHIFT;
      cell_y = y_rel >> CELL_SHIFT;
      // Widen both sides so an out-of-grid col/row can never alias a cell.
      for (int i = 0; i < NUM_OBJ; i++) begin
         obj_hit[i] = active_q[i][18]
                   && ({5'd0, cell_x} == {{HW{1'b0}}, active_q[i][17:13]})
                   && ({4'd0, cell_y} == {{VW{1'b0}}, active_q[i][12:9]});
      end
      // Descending scan so the lowest-index hit wins.
      pix_rgb = BG_COLOR;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (obj_hit[i]) begin
            pix_rgb = active_q[i][8:0];
         end
      end
      rgb_s1_d = video ? pix_rgb : 9'd0;
      hs_s1_d  = !(32'(h_count_q) < H_SYNC);
      vs_s1_d  = !(32'(v_count_q) < V_SYNC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_count_q     <= '0;
         v_count_q     <= '0;
         frame_start_q <= 1'b0;
         rgb_s1_q      <= '0;
         hs_s1_q       <= 1'b1;
         vs_s1_q       <= 1'b1;
         rgb_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         for (int i = 0; i < NUM_OBJ; i++) begin
            shadow_q[i] <= {1'b0, shadow_q[i][17:0]};
            active_q[i] <= {1'b0, active_q[i][17:0]};
         end
      end else begin
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
         frame_start_q <= frame_start_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         rgb_s1_q      <= rgb_s1_d;
         hs_s1_q       <= hs_s1_d;
         vs_s1_q       <= vs_s1_d;
         rgb_q         <= rgb_s1_q;
         hs_q          <= hs_s1_q;
         vs_q          <= vs_s1_q;
      end
   end

`ifdef VGA_COLLISION_EN
   logic hit_flag_q, hit_flag_d;
   logic collision_q, collision_d;

   // hit_flag accumulates over a frame; collision reports the finished frame.
   always_comb begin
      hit_flag_d  = hit_flag_q || (video && obj_hit[0] && (|obj_hit[NUM_OBJ-1:1]));
      collision_d = collision_q;
      if (frame_start_q) begin
         collision_d = hit_flag_q;
         hit_flag_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_flag_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         hit_flag_q  <= hit_flag_d;
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;
`else
   assign collision = 1'b0;
`endif

   assign vga_r       = rgb_q[8:6];
   assign vga_g       = rgb_q[5:3];
   assign vga_b       = rgb_q[2:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_object_renderer.sv
// Testbench for vga_object_renderer with a reduced screen geometry so many
// frames fit in a short run. A reference model predicts every output cycle
// from the cycle count since reset and a plain copy of the object tables;
// a monitor compares the DUT against the queued predictions.
module tb_vga_object_renderer;

   localparam int NUM_OBJ    = 24;
   localparam int CELL_SHIFT = 2;
   localparam int H_SYNC = 4, H_BP = 4, H_ACT = 48, H_FP = 4;
   localparam int V_SYNC = 2, V_BP = 2, V_ACT = 20, V_FP = 2;
   localparam logic [8:0] BG = 9'b000_100_000;
   localparam int HT    = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int VT    = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int FRAME = HT * VT;
   localparam int CELL  = 1 << CELL_SHIFT;
   localparam int AW    = $clog2(NUM_OBJ);

   logic          clk = 1'b0;
   logic          rst;
   logic          obj_we;
   logic [AW-1:0] obj_addr;
   logic [18:0]   obj_wdata;
   logic [2:0]    vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, frame_start, collision;

   vga_object_renderer #(
      .NUM_OBJ(NUM_OBJ), .CELL_SHIFT(CELL_SHIFT),
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
      .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .obj_we(obj_we), .obj_addr(obj_addr),
      .obj_wdata(obj_wdata), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start),
      .collision(collision)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected per-cycle output: {hs, vs, rgb[8:0], frame_start, collision}
   logic [12:0] exp_q[$];

   logic [18:0] m_shadow [NUM_OBJ];
   logic [18:0] m_active [NUM_OBJ];
   int          n;
   bit          m_hit, m_coll;
   logic [10:0] m_d1, m_out;
   bit          m_fs, m_last;

   function automatic bit in_video(int cyc, output int cx, output int cy);
      int h, v;
      h  = cyc % HT;
      v  = (cyc / HT) % VT;
      cx = (h - H_SYNC - H_BP) / CELL;
      cy = (v - V_SYNC - V_BP) / CELL;
      return (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
             (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
   endfunction

   function automatic bit obj_at(int i, int cx, int cy);
      return m_active[i][18] && (int'(m_active[i][17:13]) == cx) &&
             (int'(m_active[i][12:9]) == cy);
   endfunction

   function automatic logic [10:0] pixel_at(int cyc);
      int cx, cy;
      logic [8:0] c;
      bit found;
      c = 9'd0;
      if (in_video(cyc, cx, cy)) begin
         c = BG;
         found = 1'b0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (!found && obj_at(i, cx, cy)) begin
               c = m_active[i][8:0];
               found = 1'b1;
            end
         end
      end
      return {1'((cyc % HT) >= H_SYNC), 1'(((cyc / HT) % VT) >= V_SYNC), c};
   endfunction

   function automatic bit collide_at(int cyc);
      int cx, cy;
      bit other;
      other = 1'b0;
      if (!in_video(cyc, cx, cy) || !obj_at(0, cx, cy)) return 1'b0;
      for (int i = 1; i < NUM_OBJ; i++) other |= obj_at(i, cx, cy);
      return other;
   endfunction

   // Reference model: one step per clock edge, inputs as sampled at that edge.
   initial begin
      n = 0; m_hit = 0; m_coll = 0; m_d1 = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            n = 0; m_hit = 0; m_coll = 0;
            for (int i = 0; i < NUM_OBJ; i++) begin
               m_shadow[i][18] = 1'b0;
               m_active[i][18] = 1'b0;
            end
            m_d1 = 11'h600;
            exp_q.push_back({11'h600, 2'b00});
         end else begin
            m_out  = m_d1;
            m_d1   = pixel_at(n);
            m_last = ((n % HT) == HT - 1) && (((n / HT) % VT) == VT - 1);
`ifdef VGA_COLLISION_EN
            if (m_last) begin
               m_coll = m_hit;
               m_hit  = 1'b0;
            end else if (collide_at(n)) begin
               m_hit = 1'b1;
            end
`endif
            if (m_last) for (int i = 0; i < NUM_OBJ; i++) m_active[i] = m_shadow[i];
            if (obj_we && (int'(obj_addr) < NUM_OBJ)) m_shadow[obj_addr] = obj_wdata;
            n = n + 1;
            m_fs = ((n % HT) == HT - 1) && (((n / HT) % VT) == VT - 1);
            exp_q.push_back({m_out, m_fs, m_coll});
         end
      end
   end

   // Monitor: one output per clock, sampled on the falling edge.
   logic [12:0] e;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== e[12:2]) begin
               bad++;
               $display("FAIL video t=%0t got hs/vs/rgb=%b/%b/%h want %b/%b/%h",
                        $time, vga_hs, vga_vs, {vga_r, vga_g, vga_b},
                        e[12], e[11], e[10:2]);
            end
            total++;
            if ({frame_start, collision} !== e[1:0]) begin
               bad++;
               $display("FAIL status t=%0t got fs/coll=%b/%b want %b/%b",
                        $time, frame_start, collision, e[1], e[0]);
            end
         end
      end
   end

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int a, input bit en, input int col, input int row,
                     input logic [8:0] rgb);
      obj_we    = 1'b1;
      obj_addr  = AW'(a);
      obj_wdata = {en, 5'(col), 4'(row), rgb};
      step(1);
      obj_we    = 1'b0;
   endtask

   task automatic wait_fs();
      int k;
      k = 0;
      while (frame_start !== 1'b1 && k < 2 * FRAME) begin
         step(1);
         k++;
      end
      total++;
      if (frame_start !== 1'b1) begin
         bad++;
         $display("FAIL wait_frame_start got=%b want=1 after %0d cycles", frame_start, k);
      end
   endtask

   int fs_cnt, hs_cnt, vs_cnt;

   initial begin
      rst = 1'b1; obj_we = 1'b0; obj_addr = '0; obj_wdata = '0;
      step(4);
      rst = 1'b0;

      // One full frame of steady-state timing.
      step(5);
      fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      repeat (FRAME) begin
         fs_cnt += int'(frame_start);
         hs_cnt += int'(!vga_hs);
         vs_cnt += int'(!vga_vs);
         step(1);
      end
      total++;
      if (fs_cnt != 1) begin
         bad++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt);
      end
      total++;
      if (hs_cnt != H_SYNC * VT) begin
         bad++; $display("FAIL hs_low_count got=%0d want=%0d", hs_cnt, H_SYNC * VT);
      end
      total++;
      if (vs_cnt != V_SYNC * HT) begin
         bad++; $display("FAIL vs_low_count got=%0d want=%0d", vs_cnt, V_SYNC * HT);
      end

      // Single object, then two objects in the same cell (lower index wins).
      step(HT * 7 + 13);
      wr(3, 1, 2, 1, 9'h1C0);
      step(2 * FRAME);
      wr(5, 1, 4, 4, 9'h007);
      wr(1, 1, 4, 4, 9'h1FF);
      step(2 * FRAME);

      // Write exactly on the frame_start cycle.
      wait_fs();
      wr(6, 1, 6, 0, 9'h0F0);
      step(2 * FRAME);

      // Off-grid object and an out-of-range address.
      wr(9, 1, 20, 10, 9'h1AA);
      wr(26, 1, 0, 0, 9'h1FF);

      // Collision of object 0 and object 7, then object 7 moves away.
      wr(0, 1, 10, 3, 9'h1F8);
      wr(7, 1, 10, 3, 9'h03F);
      step(2 * FRAME);
      wr(7, 1, 0, 2, 9'h03F);
      step(3 * FRAME);

      // Reset mid-frame.
      wait_fs();
      step(HT * 10 + 30);
      rst = 1'b1;
      step(1);
      total++;
      if ({vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start} !== 12'hC00) begin
         bad++;
         $display("FAIL mid_reset got hs/vs/rgb/fs=%b/%b/%h/%b want 1/1/000/0",
                  vga_hs, vga_vs, {vga_r, vga_g, vga_b}, frame_start);
      end
      rst = 1'b0;
      step(FRAME + 17);

      // Randomized writes.
      repeat (8 * FRAME) begin
         if ($urandom_range(0, 7) == 0) begin
            obj_we    = 1'b1;
            obj_addr  = AW'($urandom_range(0, 31));
            obj_wdata = {1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 13)),
                         4'($urandom_range(0, 6)), 9'($urandom)};
         end else begin
            obj_we = 1'b0;
         end
         step(1);
      end
      obj_we = 1'b0;
      step(2 * FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
